// File: rtl/mem_access_ctrl.sv
// MEM-stage access sequencer: routes loads/stores to dmem or the IO bus and stalls the pipe.
// Latency: dmem store 0 stall cycles, dmem load DMEM_LAT+1 cycles to DONE, IO ack cycle + 1 to DONE.
// Backpressure: stall/wb_bubble hold the upstream pipeline until the access completes.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   req_valid/write/addr/wdata    MEM-stage request (stable while stall=1)
//   dmem_en/we/addr/wdata         combinational dmem strobe, IDLE only
//   dmem_rdata                    dmem read data, DMEM_LAT cycles after the strobe
//   io_req/we/addr/wdata          registered IO request, held until ack or timeout
//   io_ack/io_rdata               IO completion pulse and read data
//   stall, wb_bubble              pipeline hold and MEM/WB bubble
//   mem_rdata, rdata_valid        load result to MEM/WB, valid in DONE
//   io_err                        one-cycle pulse when an IO access times out
module mem_access_ctrl #(
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FC00,
    parameter int unsigned DMEM_LAT   = 1,
    parameter int unsigned IO_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        dmem_en,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic        io_req,
    output logic        io_we,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic        io_ack,
    input  logic [31:0] io_rdata,
    output logic        stall,
    output logic        wb_bubble,
    output logic [31:0] mem_rdata,
    output logic        rdata_valid,
    output logic        io_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DMEM_WAIT = 2'd1,
        IO_WAIT   = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(DMEM_LAT - 1);
    localparam logic [7:0] TO_LAST  = 8'(IO_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic [31:0] io_addr_q, io_addr_d;
    logic [31:0] io_wdata_q, io_wdata_d;
    logic        io_we_q, io_we_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        rd_q, rd_d;          // access in flight is a load
    logic        io_err_q, io_err_d;

    logic is_io;
    logic to_hit;

    assign is_io  = (req_addr >= IO_BASE);
    // to_cnt_q counts completed wait cycles; this is the IO_TIMEOUT-th one.
    assign to_hit = (to_cnt_q == TO_LAST);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (is_io) begin
                        state_d = IO_WAIT;
                    end else if (!req_write) begin
                        state_d = DMEM_WAIT;
                    end
                end
            end
            DMEM_WAIT: begin
                if (lat_cnt_q == 3'd0) begin
                    state_d = DONE;
                end
            end
            IO_WAIT: begin
                if (io_ack || to_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Request-driven outputs are gated by rstn so a stale
    // request cannot strobe memory or stall the pipe while reset is held.
    always_comb begin
        dmem_en     = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = 32'h0;
        dmem_wdata  = 32'h0;
        stall       = 1'b0;
        wb_bubble   = 1'b0;
        io_req      = 1'b0;
        rdata_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (rstn && req_valid) begin
                    if (is_io) begin
                        stall = 1'b1;
                    end else begin
                        dmem_en    = 1'b1;
                        dmem_we    = req_write;
                        dmem_addr  = req_addr;
                        dmem_wdata = req_wdata;
                        stall      = !req_write;
                    end
                    wb_bubble = stall;
                end
            end
            DMEM_WAIT: begin
                stall     = 1'b1;
                wb_bubble = 1'b1;
            end
            IO_WAIT: begin
                io_req    = 1'b1;
                stall     = 1'b1;
                wb_bubble = 1'b1;
            end
            DONE: begin
                rdata_valid = rd_q;
            end
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        lat_cnt_d   = lat_cnt_q;
        to_cnt_d    = to_cnt_q;
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        io_we_d     = io_we_q;
        mem_rdata_d = mem_rdata_q;
        rd_d        = rd_q;
        io_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && is_io) begin
                    io_addr_d  = req_addr;
                    io_wdata_d = req_wdata;
                    io_we_d    = req_write;
                    to_cnt_d   = 8'd0;
                    rd_d       = !req_write;
                end else if (req_valid && !req_write) begin
                    lat_cnt_d = LAT_LOAD;
                    rd_d      = 1'b1;
                end
            end
            DMEM_WAIT: begin
                if (lat_cnt_q == 3'd0) begin
                    mem_rdata_d = dmem_rdata;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            IO_WAIT: begin
                // An ack in the timeout cycle takes priority over the timeout.
                if (io_ack) begin
                    if (!io_we_q) begin
                        mem_rdata_d = io_rdata;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                    if (to_hit) begin
                        io_err_d    = 1'b1;
                        mem_rdata_d = 32'h0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_cnt_q   <= 3'd0;
            to_cnt_q    <= 8'd0;
            io_addr_q   <= 32'h0;
            io_wdata_q  <= 32'h0;
            io_we_q     <= 1'b0;
            mem_rdata_q <= 32'h0;
            rd_q        <= 1'b0;
            io_err_q    <= 1'b0;
        end else begin
            lat_cnt_q   <= lat_cnt_d;
            to_cnt_q    <= to_cnt_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
            io_we_q     <= io_we_d;
            mem_rdata_q <= mem_rdata_d;
            rd_q        <= rd_d;
            io_err_q    <= io_err_d;
        end
    end

    assign io_we     = io_we_q;
    assign io_addr   = io_addr_q;
    assign io_wdata  = io_wdata_q;
    assign mem_rdata = mem_rdata_q;
    assign io_err    = io_err_q;

endmodule
